regfile_wb_arbiter: RTL and testbench

Shares the single register-file write port between two writeback producers: requester 0 is the ALU writeback and requester 1 is the load/memory writeback. Each requester gets a 1-entry holding buffer behind a valid/ready handshake. Conflicts are resolved by round-robin arbitration, and the block drives registered wr_en/wr_addr/wr_data into the register file. A per-register pending scoreboard, set at decode and cleared at write commit, gives read-after-write hazard flags for the two read addresses.

---
 rtl/regfile_wb_arbiter.sv | 109 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin sharing of the register-file write port between ALU and load writeback, with a pending-write scoreboard
module regfile_wb_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int NUM_REGS  = 32,
    parameter int ZERO_DROP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    input  logic              rsv_valid,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic              hazard_rs,
    output logic              hazard_rt,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              grant_id
);
    logic              hold0_valid, hold1_valid, last_grant;
    logic [ADDR_W-1:0] hold0_addr, hold1_addr;
    logic [DATA_W-1:0] hold0_data, hold1_data;
    logic [NUM_REGS-1:0] pending, pending_nxt;
    logic grant0, grant1, acc0, acc1, keep0, keep1, rsv_set;

    // grants depend only on hold state and last_grant, so ready never looks at valid
    always_comb begin
        grant0     = hold0_valid && (!hold1_valid || last_grant);
        grant1     = hold1_valid && (!hold0_valid || !last_grant);
        req0_ready = !hold0_valid || grant0;
        req1_ready = !hold1_valid || grant1;
        acc0       = req0_valid && req0_ready;
        acc1       = req1_valid && req1_ready;
        keep0      = acc0 && !(ZERO_DROP != 0 && req0_addr == '0);
        keep1      = acc1 && !(ZERO_DROP != 0 && req1_addr == '0);
        rsv_set    = rsv_valid && !(ZERO_DROP != 0 && rsv_addr == '0);
        hazard_rs  = pending[rs];
        hazard_rt  = pending[rt];
    end

    // commit clears the written register; a same-edge reservation re-sets it
    always_comb begin
        pending_nxt = pending;
        if (wr_en) pending_nxt[wr_addr] = 1'b0;
        if (rsv_set) pending_nxt[rsv_addr] = 1'b1;
    end

    // holding buffers: a granted entry empties unless refilled on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold0_valid <= 1'b0;
            hold1_valid <= 1'b0;
            hold0_addr  <= '0;
            hold1_addr  <= '0;
            hold0_data  <= '0;
            hold1_data  <= '0;
        end else if (flush) begin
            hold0_valid <= 1'b0;
            hold1_valid <= 1'b0;
        end else begin
            hold0_valid <= keep0 || (hold0_valid && !grant0);
            hold1_valid <= keep1 || (hold1_valid && !grant1);
            if (keep0) begin
                hold0_addr <= req0_addr;
                hold0_data <= req0_data;
            end
            if (keep1) begin
                hold1_addr <= req1_addr;
                hold1_data <= req1_data;
            end
        end
    end

    // registered write port; address and data hold their last value when idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            grant_id   <= 1'b0;
            last_grant <= 1'b1;
        end else if (flush || !(grant0 || grant1)) begin
            wr_en <= 1'b0;
        end else begin
            wr_en      <= 1'b1;
            wr_addr    <= grant0 ? hold0_addr : hold1_addr;
            wr_data    <= grant0 ? hold0_data : hold1_data;
            grant_id   <= grant1;
            last_grant <= grant1;
        end
    end

    // pending-write scoreboard
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pending <= '0;
        else if (flush) pending <= '0;
        else pending <= pending_nxt;
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed scoreboard bench for the writeback arbiter
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0, rst = 1'b1, flush = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0, rsv_valid = 1'b0;
    logic [4:0]  req0_addr = '0, req1_addr = '0, rsv_addr = '0, rs = '0, rt = '0;
    logic [31:0] req0_data = '0, req1_data = '0;
    logic        req0_ready, req1_ready, hazard_rs, hazard_rt, wr_en, grant_id;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    int passed = 0, total = 0;
    logic [37:0] sb[$];

    regfile_wb_arbiter dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rs(rs), .rt(rt),
        .hazard_rs(hazard_rs), .hazard_rt(hazard_rt),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input logic gid, input logic [4:0] a, input logic [31:0] d);
        sb.push_back({gid, a, d});
    endtask

    task automatic tick();
        logic [37:0] e;
        @(posedge clk);
        #1;
        if (wr_en === 1'b1) begin
            if (sb.size() == 0) check("wr_unexpected", {63'b0, wr_en}, 64'd0);
            else begin
                e = sb.pop_front();
                check("wr_addr", {59'b0, wr_addr}, {59'b0, e[36:32]});
                check("wr_data", {32'b0, wr_data}, {32'b0, e[31:0]});
                check("grant_id", {63'b0, grant_id}, {63'b0, e[37]});
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int i0, i1, n;
        logic a0, a1;
        tick();
        check("rst_wr_en", {63'b0, wr_en}, 64'd0);
        check("rst_wr_addr", {59'b0, wr_addr}, 64'd0);
        check("rst_wr_data", {32'b0, wr_data}, 64'd0);
        check("rst_grant_id", {63'b0, grant_id}, 64'd0);
        check("rst_ready0", {63'b0, req0_ready}, 64'd1);
        check("rst_ready1", {63'b0, req1_ready}, 64'd1);
        rst = 1'b0;

        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
        push(1'b0, 5'd5, 32'hDEADBEEF);
        tick();
        req0_valid = 1'b0;
        check("t1_wr_en_e0", {63'b0, wr_en}, 64'd0);
        tick();
        check("t1_wr_en_e1", {63'b0, wr_en}, 64'd1);
        ticks(3);
        check("t1_sb_empty", 64'(sb.size()), 64'd0);

        do_reset();
        for (int k = 0; k < 4; k++) begin
            push(1'b0, 5'(k + 1), 32'hA0 + k);
            push(1'b1, 5'(k + 9), 32'hB0 + k);
        end
        i0 = 0; i1 = 0; n = 0;
        while ((i0 < 4 || i1 < 4) && n < 40) begin
            req0_valid = (i0 < 4); req0_addr = 5'(i0 + 1); req0_data = 32'hA0 + i0;
            req1_valid = (i1 < 4); req1_addr = 5'(i1 + 9); req1_data = 32'hB0 + i1;
            if (n >= 1) check("t2_ready_alt", {63'b0, req0_ready ^ req1_ready}, 64'd1);
            a0 = req0_valid && req0_ready;
            a1 = req1_valid && req1_ready;
            tick();
            if (a0) i0++;
            if (a1) i1++;
            n++;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("t2_accepted", 64'(i0 + i1), 64'd8);
        ticks(4);
        check("t2_sb_empty", 64'(sb.size()), 64'd0);

        rsv_valid = 1'b1; rsv_addr = 5'd7; rs = 5'd7; rt = 5'd7;
        tick();
        rsv_valid = 1'b0;
        check("t3_hz_set", {63'b0, hazard_rs}, 64'd1);
        check("t3_hz_rt", {63'b0, hazard_rt}, 64'd1);
        req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'h77;
        push(1'b1, 5'd7, 32'h77);
        tick();
        req1_valid = 1'b0;
        check("t3_hz_acc", {63'b0, hazard_rs}, 64'd1);
        tick();
        check("t3_wr_cycle", {63'b0, wr_en}, 64'd1);
        check("t3_hz_wr", {63'b0, hazard_rs}, 64'd1);
        tick();
        check("t3_hz_clr", {63'b0, hazard_rs}, 64'd0);
        req1_valid = 1'b1; req1_data = 32'h78;
        push(1'b1, 5'd7, 32'h78);
        tick();
        req1_valid = 1'b0;
        tick();
        rsv_valid = 1'b1; rsv_addr = 5'd7;
        tick();
        rsv_valid = 1'b0;
        check("t3_hz_setwins", {63'b0, hazard_rs}, 64'd1);

        req0_valid = 1'b1; req0_addr = 5'd0; req0_data = 32'h55;
        check("t4_ready0", {63'b0, req0_ready}, 64'd1);
        tick();
        req0_valid = 1'b0;
        check("t4_ready0_after", {63'b0, req0_ready}, 64'd1);
        ticks(3);
        check("t4_no_wr", {63'b0, wr_en}, 64'd0);
        rsv_valid = 1'b1; rsv_addr = 5'd0; rs = 5'd0;
        tick();
        rsv_valid = 1'b0;
        check("t4_hz_r0", {63'b0, hazard_rs}, 64'd0);

        req0_valid = 1'b1; req0_addr = 5'd20; req0_data = 32'h20;
        req1_valid = 1'b1; req1_addr = 5'd21; req1_data = 32'h21;
        rsv_valid = 1'b1; rsv_addr = 5'd3; rs = 5'd3;
        tick();
        rsv_valid = 1'b0; req1_valid = 1'b0;
        req0_addr = 5'd22; req0_data = 32'h22;
        flush = 1'b1;
        check("t5_hz_pre", {63'b0, hazard_rs}, 64'd1);
        tick();
        flush = 1'b0; req0_valid = 1'b0;
        check("t5_wr_en", {63'b0, wr_en}, 64'd0);
        check("t5_ready0", {63'b0, req0_ready}, 64'd1);
        check("t5_ready1", {63'b0, req1_ready}, 64'd1);
        check("t5_hz", {63'b0, hazard_rs}, 64'd0);
        ticks(3);
        check("t5_sb_empty", 64'(sb.size()), 64'd0);

        req1_valid = 1'b1; req1_addr = 5'd15; req1_data = 32'h15;
        rsv_valid = 1'b1; rsv_addr = 5'd15; rs = 5'd15;
        push(1'b1, 5'd15, 32'h15);
        tick();
        rsv_valid = 1'b0;
        req1_addr = 5'd16; req1_data = 32'h16;
        tick();
        req1_valid = 1'b0;
        check("t6_gid_pre", {63'b0, grant_id}, 64'd1);
        check("t6_hz_pre", {63'b0, hazard_rs}, 64'd1);
        #2 rst = 1'b1;
        #1;
        check("t6_wr_en", {63'b0, wr_en}, 64'd0);
        check("t6_gid", {63'b0, grant_id}, 64'd0);
        check("t6_hz", {63'b0, hazard_rs}, 64'd0);
        #1 rst = 1'b0;
        tick();
        req1_valid = 1'b1; req1_addr = 5'd17; req1_data = 32'h17;
        push(1'b1, 5'd17, 32'h17);
        tick();
        req1_valid = 1'b0;
        ticks(2);
        req0_valid = 1'b1; req0_addr = 5'd18; req0_data = 32'h18;
        req1_valid = 1'b1; req1_addr = 5'd19; req1_data = 32'h19;
        push(1'b0, 5'd18, 32'h18);
        push(1'b1, 5'd19, 32'h19);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        ticks(4);
        check("t6_sb_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
